pe_spad_loader: RTL
===================

Name: pe_spad_loader

Overview:
- Downstream consumer of the 32-deep, 32-bit PE input FIFO.
- Pops packed words ({hi[15:0], lo[15:0]}) from the FIFO, unpacks them into a local 16-bit scratchpad (ifmap/filter spad), then exposes the spad to the PE datapath for random-access reads until the PE releases it.
- Sits between the FIFO read port and the PE MAC.

Parameters:
- SPAD_DEPTH, 12, number of 16-bit spad entries.
- AW, 4, spad address width; must satisfy 2^AW >= SPAD_DEPTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  load request; sampled only in IDLE.
- len  in  AW+1  number of 16-bit elements to load, legal 1..SPAD_DEPTH; sampled with start.
- fifo_empty  in  1  FIFO empty flag.
- fifo_push_obs  in  1  copy of the FIFO push input; a push in the same cycle cancels a pop.
- fifo_pop  out  1  pop request to the FIFO.
- fifo_dout  in  32  FIFO read data, valid the cycle after an accepted pop.
- busy  out  1  high in LOAD or DRAIN.
- spad_ready  out  1  high in READY.
- rd_en  in  1  PE read strobe.
- rd_addr  in  AW  PE read address.
- rd_data  out  16  registered read data.
- release  in  1  PE finished with the spad.

Behaviour:
- Reset: state=IDLE; fifo_pop=0, busy=0, spad_ready=0, rd_data=0; all counters 0; all spad entries cleared to 0. Reset mid-load abandons the load; no pending capture survives.
- States: IDLE, LOAD, DRAIN, READY.
- IDLE:
  - start with 1<=len<=SPAD_DEPTH: latch len; words_needed=ceil(len/2); go to LOAD.
  - start with len=0 or len>SPAD_DEPTH: ignored, stay in IDLE.
- LOAD:
  - fifo_pop = ~fifo_empty & (words_issued < words_needed), combinational.
  - Accepted pop: acc = fifo_pop & ~fifo_empty & ~fifo_push_obs. Only an accepted pop increments words_issued. A cancelled pop (fifo_push_obs=1) is simply retried on a later cycle.
  - pend <= acc. In the cycle pend=1, fifo_dout is written:
    - lo to spad[wr_ptr];
    - hi to spad[wr_ptr+1], only if wr_ptr+1 < len (for odd len the last hi half is discarded).
    - wr_ptr advances by 2, saturating at len.
  - When the final accepted pop is issued, go to DRAIN.
- DRAIN:
  - fifo_pop=0.
  - Capture the final word (pend=1 this cycle), then go to READY.
  - Load latency from start with a continuously non-empty FIFO and no push collisions: words_needed+2 cycles to spad_ready.
- READY:
  - spad_ready=1.
  - rd_en=1: rd_data <= spad[rd_addr] next cycle if rd_addr < len, else rd_data <= 0.
  - rd_en=0: rd_data holds its value.
  - release=1: go to IDLE next cycle. Spad contents are kept until overwritten by the next load.
- Outside READY: rd_en is ignored and rd_data holds.
- start while not in IDLE: ignored. release outside READY: ignored.
- fifo_empty during LOAD: fifo_pop drops and the FSM stalls in LOAD with no timeout.
- Reads during LOAD are not served.

Test Plan:
- Basic load:
  - Stimulus: FIFO preloaded with 6 words 0x0001_0000, 0x0003_0002, … 0x000B_000A; start with len=12.
  - Required: 6 pops on consecutive cycles; spad_ready asserted 8 cycles after start; reading addr 0..11 gives 0x0000..0x000B, each one cycle after rd_en.
- Odd length:
  - Stimulus: len=5, FIFO words 0xBBBB_AAAA, 0xDDDD_CCCC, 0xFFFF_EEEE.
  - Required: spad[0..4] = AAAA, BBBB, CCCC, DDDD, EEEE; 0xFFFF is not stored; reading addr 5 returns 0.
- Push collision:
  - Stimulus: assert fifo_push_obs on the 2nd and 3rd pop cycles of a len=4 load.
  - Required: exactly 2 accepted pops; fifo_pop is held high through the cancelled cycles; spad contents are correct; spad_ready is delayed by 2 cycles.
- Empty stall:
  - Stimulus: FIFO holds 1 word, len=4; push a 2nd word 10 cycles later.
  - Required: busy stays 1 and fifo_pop stays 0 while empty; load completes after the 2nd word arrives.
- Illegal and ignored controls:
  - Stimulus: start with len=0 and with len=13; start during LOAD; release in IDLE.
  - Required: no state change in every case and no fifo_pop.
- Reset mid-operation:
  - Stimulus: assert rstn=0 during LOAD after 2 pops.
  - Required: immediately all outputs are 0 and state is IDLE; after reset release, reading the spad in a new len=2 load shows only the new data.

Source files
------------

// File: rtl/pe_spad_loader.sv
// PE scratchpad loader: unpacks 32-bit FIFO words into a 16-bit spad and
// serves registered random-access reads to the PE until it releases the spad.
module pe_spad_loader #(
    parameter int SPAD_DEPTH = 12,
    parameter int AW         = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          fifo_empty,
    input  logic          fifo_push_obs,
    output logic          fifo_pop,
    input  logic [31:0]   fifo_dout,
    output logic          busy,
    output logic          spad_ready,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    input  logic          spad_release
);
    // state | meaning
    // IDLE  | waiting for a start with a legal length
    // LOAD  | issuing pops, capturing the word popped last cycle
    // DRAIN | capturing the final popped word
    // READY | spad handed to the PE for reads until release
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READY} state_t;

    localparam int PW = AW + 1;

    state_t        state_q, state_d;
    logic [PW-1:0] len_q, len_d;
    logic [PW-1:0] words_needed_q, words_needed_d;
    logic [PW-1:0] words_issued_q, words_issued_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          pend_q, pend_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [15:0]   spad_q [SPAD_DEPTH];
    logic [15:0]   spad_d [SPAD_DEPTH];

    logic          len_ok;
    logic          acc;
    logic [PW-1:0] wr_ptr_hi;
    logic [PW-1:0] wr_ptr_inc;
    logic [PW-1:0] wr_ptr_nxt;
    logic [15:0]   rd_sel;

    assign len_ok     = (len != '0) && (len <= PW'(SPAD_DEPTH));
    assign fifo_pop   = (state_q == LOAD) && !fifo_empty && (words_issued_q < words_needed_q);
    assign acc        = fifo_pop && !fifo_push_obs;
    assign wr_ptr_hi  = wr_ptr_q + PW'(1);
    assign wr_ptr_inc = wr_ptr_q + PW'(2);
    assign wr_ptr_nxt = (wr_ptr_inc > len_q) ? len_q : wr_ptr_inc;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < SPAD_DEPTH; i++) begin
            if (AW'(i) == rd_addr) rd_sel = spad_q[i];
        end
    end

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        words_needed_d = words_needed_q;
        words_issued_d = words_issued_q;
        wr_ptr_d       = wr_ptr_q;
        pend_d         = 1'b0;
        rd_data_d      = rd_data_q;
        spad_d         = spad_q;

        case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    len_d          = len;
                    words_needed_d = (len >> 1) + PW'(len[0]);
                    words_issued_d = '0;
                    wr_ptr_d       = '0;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                pend_d = acc;
                if (acc) begin
                    words_issued_d = words_issued_q + PW'(1);
                    if (words_issued_q + PW'(1) == words_needed_q) state_d = DRAIN;
                end
            end
            DRAIN: state_d = READY;
            READY: begin
                if (rd_en) rd_data_d = ({1'b0, rd_addr} < len_q) ? rd_sel : 16'h0000;
                if (spad_release) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // fifo_dout is valid the cycle after an accepted pop; odd tail hi half is dropped
        if (pend_q) begin
            for (int i = 0; i < SPAD_DEPTH; i++) begin
                if (PW'(i) == wr_ptr_q) spad_d[i] = fifo_dout[15:0];
                if ((PW'(i) == wr_ptr_hi) && (wr_ptr_hi < len_q)) spad_d[i] = fifo_dout[31:16];
            end
            wr_ptr_d = wr_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= IDLE;
            len_q          <= '0;
            words_needed_q <= '0;
            words_issued_q <= '0;
            wr_ptr_q       <= '0;
            pend_q         <= 1'b0;
            rd_data_q      <= '0;
            for (int i = 0; i < SPAD_DEPTH; i++) spad_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            words_needed_q <= words_needed_d;
            words_issued_q <= words_issued_d;
            wr_ptr_q       <= wr_ptr_d;
            pend_q         <= pend_d;
            rd_data_q      <= rd_data_d;
            spad_q         <= spad_d;
        end
    end

    assign busy       = (state_q == LOAD) || (state_q == DRAIN);
    assign spad_ready = (state_q == READY);
    assign rd_data    = rd_data_q;

endmodule
